// File: rtl/multibyte_alu_sequencer_pkg.sv
// Shared op codes, FSM states and helpers for the multi-byte ALU sequencer.
package multibyte_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_ADC = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SBC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  function automatic logic is_sub(alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_SBC);
  endfunction

  function automatic logic uses_carry(alu_op_e op);
    return (op == ALU_ADC) || (op == ALU_SBC);
  endfunction

endpackage

// File: rtl/n_bit_adder_subtractor.sv
// One DATA_WIDTH add/sub slice; carry_o and half_carry_o are borrows for sub ops.
module n_bit_adder_subtractor
  import multibyte_alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  alu_op_e               op_i,
  input  logic                  carry_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic                  half_carry_o
);

  // Half carry is taken at the boundary of the top nibble of the slice.
  localparam int HW = DATA_WIDTH - 4;

  logic            cin;
  logic [DATA_WIDTH:0] full;
  logic [HW:0]     low;

  always_comb begin
    cin = uses_carry(op_i) ? carry_i : 1'b0;
    if (is_sub(op_i)) begin
      full = {1'b0, a_i} - {1'b0, b_i} - {{DATA_WIDTH{1'b0}}, cin};
      low  = {1'b0, a_i[HW-1:0]} - {1'b0, b_i[HW-1:0]} - {{HW{1'b0}}, cin};
    end else begin
      full = {1'b0, a_i} + {1'b0, b_i} + {{DATA_WIDTH{1'b0}}, cin};
      low  = {1'b0, a_i[HW-1:0]} + {1'b0, b_i[HW-1:0]} + {{HW{1'b0}}, cin};
    end
    sum_o        = full[DATA_WIDTH-1:0];
    carry_o      = full[DATA_WIDTH];
    half_carry_o = low[HW];
  end

endmodule

// File: rtl/multibyte_alu_sequencer.sv
// Sequences a NUM_BYTES-wide add/sub through one shared slice, LSB first.
module multibyte_alu_sequencer
  import multibyte_alu_sequencer_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = 2,
  localparam int W = BYTE_WIDTH * NUM_BYTES
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_control,
  input  logic         i_carry,
  input  logic [W-1:0] i_data_A,
  input  logic [W-1:0] i_data_B,
  output logic         o_valid,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_subtract,
  output logic         o_half_carry,
  output logic         o_carry
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] a_q, b_q, work_q, res_d;
  alu_op_e op_q;
  logic    cin_q, chain_q;
  logic [W-1:0] result_q;
  logic    zero_q, sub_q, hc_q, carry_q;

  logic    accept, last;
  alu_op_e slice_op;
  logic    slice_cin;
  logic [BYTE_WIDTH-1:0] slice_sum;
  logic    slice_carry, slice_hc;

  n_bit_adder_subtractor #(.DATA_WIDTH(BYTE_WIDTH)) u_slice (
    .a_i          (a_q[idx_q]),
    .b_i          (b_q[idx_q]),
    .op_i         (slice_op),
    .carry_i      (slice_cin),
    .sum_o        (slice_sum),
    .carry_o      (slice_carry),
    .half_carry_o (slice_hc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    accept    = 1'b0;
    last      = (idx_q == LAST);
    slice_op  = op_q;
    slice_cin = cin_q;
    // Upper slices always chain; the stored carry is already borrow-polarity for sub.
    if (idx_q != '0) begin
      slice_op  = is_sub(op_q) ? ALU_SBC : ALU_ADC;
      slice_cin = chain_q;
    end
    res_d        = work_q;
    res_d[idx_q] = slice_sum;
    case (state_q)
      ST_IDLE: if (i_valid) begin
        accept  = 1'b1;
        idx_d   = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (last) state_d = ST_DONE;
        else      idx_d   = idx_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      op_q     <= ALU_ADD;
      cin_q    <= 1'b0;
      chain_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sub_q    <= 1'b0;
      hc_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        a_q   <= i_data_A;
        b_q   <= i_data_B;
        op_q  <= alu_op_e'(i_control);
        cin_q <= i_carry;
      end
      if (state_q == ST_EXEC) begin
        work_q  <= res_d;
        chain_q <= slice_carry;
        // Visible outputs only move on the edge into DONE.
        if (last) begin
          result_q <= res_d;
          zero_q   <= (res_d == '0);
          sub_q    <= is_sub(op_q);
          hc_q     <= slice_hc;
          carry_q  <= slice_carry;
        end
      end
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_valid      = (state_q == ST_DONE);
  assign o_result     = result_q;
  assign o_zero       = zero_q;
  assign o_subtract   = sub_q;
  assign o_half_carry = hc_q;
  assign o_carry      = carry_q;

endmodule

// File: tb/tb_multibyte_alu_sequencer.sv
// Directed bench for the 16-bit (NUM_BYTES=2) sequencer configuration.
module tb_multibyte_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic [1:0]  ctl;
  logic        cin;
  logic [15:0] da, db;
  logic        ovld;
  logic [15:0] res;
  logic        z, n, h, c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multibyte_alu_sequencer #(.BYTE_WIDTH(8), .NUM_BYTES(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(rdy),
    .i_control(ctl), .i_carry(cin), .i_data_A(da), .i_data_B(db),
    .o_valid(ovld), .o_result(res), .o_zero(z), .o_subtract(n),
    .o_half_carry(h), .o_carry(c)
  );

  // Issues one op from IDLE and waits (bounded) for o_valid; lat counts cycles after accept.
  task automatic run_op(input logic [1:0] op, input logic ci, input logic [15:0] a,
                        input logic [15:0] b, output int lat);
    @(negedge clk);
    vld = 1'b1; ctl = op; cin = ci; da = a; db = b;
    @(negedge clk);
    vld = 1'b0;
    lat = 1;
    while (!ovld && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; ctl = 2'b00; cin = 1'b0; da = '0; db = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy, ovld, res, z, n, h, c} !== {1'b1, 1'b0, 16'h0, 4'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h znhc=%b%b%b%b, want rdy=1 vld=0 res=0000 znhc=0000",
               rdy, ovld, res, z, n, h, c);
    end
    // Reset and a valid request in the same cycle: reset must win.
    vld = 1'b1; rst = 1'b1; da = 16'h1111; db = 16'h2222;
    @(negedge clk);
    vld = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ovld !== 1'b0 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_vs_accept cyc%0d: got vld=%b rdy=%b, want vld=0 rdy=1", i, ovld, rdy);
      end
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(2'b00, 1'b0, 16'h0FFF, 16'h0001, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL add_latency: got %0d, want 3", lat);
    end
    checks++;
    if ({res, z, n, h, c} !== {16'h1000, 4'b0010}) begin
      errors++;
      $display("FAIL add_0fff: got %h znhc=%b%b%b%b, want 1000 znhc=0010", res, z, n, h, c);
    end
    run_op(2'b00, 1'b0, 16'hFFFF, 16'h0001, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h0000, 4'b1011} || lat !== 3) begin
      errors++;
      $display("FAIL add_ffff: got %h znhc=%b%b%b%b lat=%0d, want 0000 znhc=1011 lat=3", res, z, n, h, c, lat);
    end
    // ADD must ignore i_carry.
    run_op(2'b00, 1'b1, 16'h1234, 16'h1111, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h2345, 4'b0000}) begin
      errors++;
      $display("FAIL add_ignore_c: got %h znhc=%b%b%b%b, want 2345 znhc=0000", res, z, n, h, c);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(2'b10, 1'b0, 16'h1000, 16'h0001, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h0FFF, 4'b0110} || lat !== 3) begin
      errors++;
      $display("FAIL sub_1000: got %h znhc=%b%b%b%b lat=%0d, want 0fff znhc=0110 lat=3", res, z, n, h, c, lat);
    end
    run_op(2'b10, 1'b0, 16'h5555, 16'h5555, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h0000, 4'b1100}) begin
      errors++;
      $display("FAIL sub_zero: got %h znhc=%b%b%b%b, want 0000 znhc=1100", res, z, n, h, c);
    end
  endtask

  task automatic test_carry_ops();
    int lat;
    run_op(2'b11, 1'b1, 16'h0000, 16'h0000, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'hFFFF, 4'b0111}) begin
      errors++;
      $display("FAIL sbc_c1: got %h znhc=%b%b%b%b, want ffff znhc=0111", res, z, n, h, c);
    end
    run_op(2'b01, 1'b1, 16'h00FF, 16'h0000, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h0100, 4'b0000}) begin
      errors++;
      $display("FAIL adc_c1: got %h znhc=%b%b%b%b, want 0100 znhc=0000", res, z, n, h, c);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [1:8];
    logic exp_vld [1:8];
    for (int i = 1; i <= 8; i++) begin
      exp_rdy[i] = (i == 4) || (i == 8);
      exp_vld[i] = (i == 3) || (i == 7);
    end
    @(negedge clk);
    vld = 1'b1; ctl = 2'b00; cin = 1'b0; da = 16'h0FFF; db = 16'h0001;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) da = 16'h7777;
      if (i == 8) vld = 1'b0;
      checks++;
      if (rdy !== exp_rdy[i] || ovld !== exp_vld[i]) begin
        errors++;
        $display("FAIL b2b_hs cyc%0d: got rdy=%b vld=%b, want rdy=%b vld=%b", i, rdy, ovld, exp_rdy[i], exp_vld[i]);
      end
      if (i == 3) begin
        checks++;
        if ({res, z, n, h, c} !== {16'h1000, 4'b0010}) begin
          errors++;
          $display("FAIL b2b_op1: got %h znhc=%b%b%b%b, want 1000 znhc=0010", res, z, n, h, c);
        end
      end
      if (i == 5) begin
        checks++;
        if (res !== 16'h1000) begin
          errors++;
          $display("FAIL b2b_hold: got %h, want 1000", res);
        end
      end
      if (i == 7) begin
        checks++;
        if ({res, z, n, h, c} !== {16'h7778, 4'b0000}) begin
          errors++;
          $display("FAIL b2b_op2: got %h znhc=%b%b%b%b, want 7778 znhc=0000", res, z, n, h, c);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    vld = 1'b1; ctl = 2'b00; cin = 1'b0; da = 16'hFFFF; db = 16'h0001;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rdy, ovld, res, z, n, h, c} !== {1'b1, 1'b0, 16'h0, 4'b0}) begin
      errors++;
      $display("FAIL midop_reset: got rdy=%b vld=%b res=%h znhc=%b%b%b%b, want rdy=1 vld=0 res=0000 znhc=0000",
               rdy, ovld, res, z, n, h, c);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ovld !== 1'b0) begin
        errors++;
        $display("FAIL midop_no_valid cyc%0d: got vld=%b, want 0", i, ovld);
      end
    end
    run_op(2'b00, 1'b0, 16'h0FFF, 16'h0001, lat);
    checks++;
    if ({res, z, n, h, c} !== {16'h1000, 4'b0010} || lat !== 3) begin
      errors++;
      $display("FAIL midop_recover: got %h znhc=%b%b%b%b lat=%0d, want 1000 znhc=0010 lat=3", res, z, n, h, c, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_ops();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
